// File: rtl/branch_resolution_tracker_if.sv
// Decode/execute-side bundle for the branch resolution tracker: prediction
// entry from decode, resolution and flush from execute, training feedback
// and fetch redirect back toward the predictor and fetch.
// master: decode/execute pipeline side; slave: the tracker.
`timescale 1ns/1ps
interface branch_resolution_tracker_if #(
  parameter int GHR_BITS = 8
) ();
  logic                dec_valid;
  logic [31:0]         dec_pc;
  logic                dec_pred_taken;
  logic [31:0]         dec_pred_target;
  logic [GHR_BITS-1:0] dec_ghr;
  logic                dec_stall;

  logic                ex_valid;
  logic [31:0]         ex_pc;
  logic                ex_taken;
  logic [31:0]         ex_target;
  logic                pipe_flush;

  logic                fb_valid;
  logic [31:0]         fb_pc;
  logic                fb_taken;
  logic [GHR_BITS-1:0] fb_ghr;
  logic                fb_mispredict;
  logic                redirect_valid;
  logic [31:0]         redirect_pc;

  modport master (
    output dec_valid, dec_pc, dec_pred_taken, dec_pred_target, dec_ghr,
    input  dec_stall,
    output ex_valid, ex_pc, ex_taken, ex_target, pipe_flush,
    input  fb_valid, fb_pc, fb_taken, fb_ghr, fb_mispredict,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  dec_valid, dec_pc, dec_pred_taken, dec_pred_target, dec_ghr,
    output dec_stall,
    input  ex_valid, ex_pc, ex_taken, ex_target, pipe_flush,
    output fb_valid, fb_pc, fb_taken, fb_ghr, fb_mispredict,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/branch_resolution_tracker.sv
// Branch resolution tracker: in-order queue of decode-time predictions,
// matched against execute-stage resolutions to produce predictor training
// feedback and a fetch redirect on mispredict.
// Optional build macro BRT_STATS_EN adds saturating branch/mispredict counters.
`timescale 1ns/1ps
module branch_resolution_tracker #(
  parameter int DEPTH    = 4,
  parameter int GHR_BITS = 8,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  branch_resolution_tracker_if.slave  bus,
  output logic [CNT_W-1:0]            occupancy,
  output logic                        err_underflow,
  output logic                        err_pc_mismatch
`ifdef BRT_STATS_EN
  ,
  output logic [31:0]                 stat_branches,
  output logic [31:0]                 stat_mispredicts
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  function automatic logic is_mispredict(input logic        pred_taken,
                                         input logic [31:0] pred_target,
                                         input logic        act_taken,
                                         input logic [31:0] act_target);
    return (pred_taken != act_taken) ||
           (pred_taken && act_taken && (pred_target != act_target));
  endfunction

`ifdef BRT_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

  // Entry storage (data only, never reset)
  logic [31:0]         pc_mem    [DEPTH];
  logic                taken_mem [DEPTH];
  logic [31:0]         tgt_mem   [DEPTH];
  logic [GHR_BITS-1:0] ghr_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] occ_q;

  logic                full, empty, pop, push, mispred, clear;
  logic [31:0]         head_pc, head_tgt, next_pc;
  logic                head_taken;
  logic [GHR_BITS-1:0] head_ghr;

  // Stage p0: head lookup, mispredict decision, push/pop/clear control
  assign full       = (occ_q == CNT_W'(DEPTH));
  assign empty      = (occ_q == '0);
  assign pop        = bus.ex_valid & ~empty;
  assign head_pc    = pc_mem[rd_ptr_q];
  assign head_taken = taken_mem[rd_ptr_q];
  assign head_tgt   = tgt_mem[rd_ptr_q];
  assign head_ghr   = ghr_mem[rd_ptr_q];
  assign mispred    = pop & is_mispredict(head_taken, head_tgt, bus.ex_taken, bus.ex_target);
  assign clear      = mispred | bus.pipe_flush;
  // A pop frees a slot in the same cycle, so a full queue still accepts a push.
  assign bus.dec_stall = full & ~pop;
  assign push       = bus.dec_valid & ~bus.dec_stall;
  assign next_pc    = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;

  // Queue pointers and occupancy; mispredict or flush discards everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q <= occ_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Capture the decode-time prediction into the tail slot
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= bus.dec_pc;
      taken_mem[wr_ptr_q] <= bus.dec_pred_taken;
      tgt_mem[wr_ptr_q]   <= bus.dec_pred_target;
      ghr_mem[wr_ptr_q]   <= bus.dec_ghr;
    end
  end

  // Stage p1: registered feedback and redirect, one-cycle pulses
  logic                fb_vld_p1, fb_taken_p1, fb_mis_p1, redirect_vld_p1;
  logic [31:0]         fb_pc_p1, redirect_pc_p1;
  logic [GHR_BITS-1:0] fb_ghr_p1;

  // Feedback register; the exception path owns fetch, so flush masks redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_vld_p1       <= 1'b0;
      fb_pc_p1        <= '0;
      fb_taken_p1     <= 1'b0;
      fb_ghr_p1       <= '0;
      fb_mis_p1       <= 1'b0;
      redirect_vld_p1 <= 1'b0;
      redirect_pc_p1  <= '0;
    end else begin
      fb_vld_p1       <= pop;
      redirect_vld_p1 <= mispred & ~bus.pipe_flush;
      if (pop) begin
        fb_pc_p1       <= bus.ex_pc;
        fb_taken_p1    <= bus.ex_taken;
        fb_ghr_p1      <= head_ghr;
        fb_mis_p1      <= mispred;
        redirect_pc_p1 <= next_pc;
      end
    end
  end

  // Sticky protocol error flags, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underflow   <= 1'b0;
      err_pc_mismatch <= 1'b0;
    end else begin
      if (bus.ex_valid && empty)        err_underflow   <= 1'b1;
      if (pop && (head_pc != bus.ex_pc)) err_pc_mismatch <= 1'b1;
    end
  end

`ifdef BRT_STATS_EN
  // Counters advance on the pop so they move together with the fb_valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (pop)     stat_branches    <= sat_inc(stat_branches);
      if (mispred) stat_mispredicts <= sat_inc(stat_mispredicts);
    end
  end
`endif

  assign occupancy          = occ_q;
  assign bus.fb_valid       = fb_vld_p1;
  assign bus.fb_pc          = fb_pc_p1;
  assign bus.fb_taken       = fb_taken_p1;
  assign bus.fb_ghr         = fb_ghr_p1;
  assign bus.fb_mispredict  = fb_mis_p1;
  assign bus.redirect_valid = redirect_vld_p1;
  assign bus.redirect_pc    = redirect_pc_p1;

endmodule
